// File: rtl/msk_rnd_pkg.sv
// Shared types and constants for the masked S-box randomness source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package msk_rnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_READY
    } st_t;

    localparam int LFSR_W     = 64;
    localparam int TAP0       = 63;
    localparam int TAP1       = 62;
    localparam int TAP2       = 60;
    localparam int TAP3       = 59;
    localparam int SEED_WORDS = 2;
    localparam int SEED_W     = LFSR_W / SEED_WORDS;

    // x^64+x^63+x^61+x^60+1, shifting toward the MSB
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]};
    endfunction

endpackage

// File: rtl/msk_lfsr_unroll.sv
// Combinational STEPS-step LFSR next-state function.
// Latency: 0 cycles (pure logic).
// Backpressure: none; caller decides when to register the result.
module msk_lfsr_unroll
    import msk_rnd_pkg::*;
#(
    parameter int STEPS = 6
) (
    input  logic [LFSR_W-1:0] s_cur,
    output logic [LFSR_W-1:0] s_nxt
);

    always_comb begin : unroll
        logic [LFSR_W-1:0] acc;
        acc = s_cur;
        for (int i = 0; i < STEPS; i++) begin
            acc = lfsr_step(acc);
        end
        s_nxt = acc;
    end

endmodule

// File: rtl/msk_rnd_src_bt.sv
// Seeded LFSR randomness source and BT clear sequencer for the masked SKINNY S-box.
// Latency: rnd_valid_o rises 2+WARMUP cycles after the first seed strobe; data registered.
// Backpressure: run_i low stalls the LFSR and holds outputs; no flow control on clear.
module msk_rnd_src_bt
    import msk_rnd_pkg::*;
#(
    parameter int D          = 2,
    parameter int RND_W      = D * (D - 1),
    parameter int BT_W       = 4,
    parameter int WARMUP     = 64,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       seed_i,
    input  logic              seed_valid_i,
    input  logic              run_i,
    input  logic              clear_req_i,
    output logic [RND_W-1:0]  rnd_o,
    output logic [BT_W-1:0]   rnd_bt_o,
    output logic              rnd_valid_o,
    output logic              clear_o,
    output logic              busy_o
);

    localparam int OUT_W = RND_W + BT_W;
    localparam int WCW   = $clog2(WARMUP + 2);
    localparam int SCW   = $clog2(SEED_WORDS + 1);
    localparam int CCW   = $clog2(CLR_CYCLES + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);

    st_t               st;
    logic [LFSR_W-1:0] s;
    logic [LFSR_W-1:0] s_adv;
    logic [LFSR_W-1:0] s_shift;
    logic [LFSR_W-1:0] s_seed;
    logic [WCW-1:0]    warm_cnt;
    logic [SCW-1:0]    word_cnt;
    logic              word_last;
    logic [CCW-1:0]    clr_cnt;
    logic              clr_req_q;

    msk_lfsr_unroll #(
        .STEPS (OUT_W)
    ) u_unroll (
        .s_cur (s),
        .s_nxt (s_adv)
    );

    assign s_shift   = {s[LFSR_W-SEED_W-1:0], seed_i};
    // an all-zero state would lock the LFSR forever
    assign s_seed    = (s_shift == '0) ? LFSR_W'(1) : s_shift;
    assign word_last = (word_cnt == SCW'(SEED_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_IDLE;
            s           <= '0;
            warm_cnt    <= '0;
            word_cnt    <= '0;
            rnd_o       <= '0;
            rnd_bt_o    <= '0;
            rnd_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (seed_valid_i) begin
                        s        <= s_shift;
                        word_cnt <= SCW'(1);
                        st       <= ST_LOAD;
                        busy_o   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (seed_valid_i) begin
                        if (word_last) begin
                            s        <= s_seed;
                            warm_cnt <= '0;
                            if (WARMUP == 0) begin
                                st          <= ST_READY;
                                busy_o      <= 1'b0;
                                rnd_valid_o <= 1'b1;
                                rnd_o       <= s_seed[RND_W-1:0];
                                rnd_bt_o    <= s_seed[RND_W +: BT_W];
                            end else begin
                                st <= ST_WARM;
                            end
                        end else begin
                            s        <= s_shift;
                            word_cnt <= word_cnt + SCW'(1);
                        end
                    end
                end
                ST_WARM: begin
                    s <= s_adv;
                    if (warm_cnt == WARM_LAST) begin
                        st          <= ST_READY;
                        busy_o      <= 1'b0;
                        rnd_valid_o <= 1'b1;
                        rnd_o       <= s_adv[RND_W-1:0];
                        rnd_bt_o    <= s_adv[RND_W +: BT_W];
                    end else begin
                        warm_cnt <= warm_cnt + WCW'(1);
                    end
                end
                ST_READY: begin
                    // a reseed takes priority over consumption
                    if (seed_valid_i) begin
                        s           <= s_shift;
                        word_cnt    <= SCW'(1);
                        st          <= ST_LOAD;
                        busy_o      <= 1'b1;
                        rnd_valid_o <= 1'b0;
                        rnd_o       <= '0;
                        rnd_bt_o    <= '0;
                    end else if (run_i) begin
                        s        <= s_adv;
                        rnd_o    <= s_adv[RND_W-1:0];
                        rnd_bt_o <= s_adv[RND_W +: BT_W];
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // clear pulse stretcher, triggered only on a rising request edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_req_q <= 1'b0;
            clr_cnt   <= '0;
            clear_o   <= 1'b0;
        end else begin
            clr_req_q <= clear_req_i;
            if (clear_req_i && !clr_req_q) begin
                clr_cnt <= CCW'(CLR_CYCLES);
                clear_o <= 1'b1;
            end else if (clr_cnt != '0) begin
                clr_cnt <= clr_cnt - CCW'(1);
                clear_o <= (clr_cnt > CCW'(1));
            end else begin
                clear_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/msk_rnd_src_bt.md
Name: msk_rnd_src_bt

Overview:
- Fresh-randomness source directly upstream of the masked SKINNY S-box with Borrowed-Time (BT) clearing.
- Each cycle it supplies the S-box's `rnd` bus (two HPC2 AND gadgets) and the 4-bit `rnd_BT` accumulator input from a seeded, unrolled 64-bit LFSR.
- It also generates the S-box `clear` request that triggers the fresh-randomness wipe.
- Seeding, warm-up, run/stall and clear sequencing are handled by a small FSM.

Parameters:
- D, 2, number of shares; must match the S-box.
- RND_W, D*(D-1), width of `rnd_o`; equals 2*and_pini_nrnd of the S-box.
- BT_W, 4, width of `rnd_bt_o`; fixed by the BT accumulator shift step.
- WARMUP, 64, LFSR steps discarded after seeding (0 allowed).
- CLR_CYCLES, 2, number of cycles `clear_o` is held high per request (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_i  in  32  seed word.
- seed_valid_i  in  1  seed word strobe; 2 words form one seed.
- run_i  in  1  advance LFSR this cycle (S-box consuming).
- clear_req_i  in  1  request BT clear of the downstream S-box.
- rnd_o  out  RND_W  fresh randomness to S-box `rnd`.
- rnd_bt_o  out  BT_W  fresh randomness to S-box `rnd_BT`.
- rnd_valid_o  out  1  outputs carry seeded, warmed-up randomness.
- clear_o  out  1  drives S-box `clear` (level; the S-box edge-detects it).
- busy_o  out  1  high in LOAD or WARM.

Behaviour:
- Reset (async, rst_n=0): state=64'h0, FSM=IDLE, warm counter=0, seed word count=0, clear counter=0. All outputs 0.
- LFSR step: bit shift left by one, `s <= {s[62:0], s[63]^s[62]^s[60]^s[59]}`. This is the maximal-length polynomial x^64+x^63+x^61+x^60+1.
- One "advance" = OUT_W = RND_W+BT_W consecutive steps, unrolled combinationally in one cycle.
- Outputs are registered slices of the current state: `rnd_o = s[RND_W-1:0]` and `rnd_bt_o = s[RND_W +: BT_W]`. Both are forced to 0 whenever `rnd_valid_o=0`.
- Seed loading: on each `seed_valid_i` in IDLE/LOAD/READY, `s <= {s[31:0], seed_i}`. The first word therefore lands in s[63:32].
- FSM states and transitions:
  - IDLE: outputs 0. `seed_valid_i` → LOAD, word count=1.
  - LOAD: second `seed_valid_i` → completes the seed and moves to WARM with warm counter=0. If WARMUP=0, go directly to READY. Non-strobe cycles hold.
  - On seed completion, if the assembled state is all-zero, the state is forced to 64'h1 (lock-up avoidance).
  - WARM: one advance per cycle regardless of `run_i`. After WARMUP advances → READY. `seed_valid_i` here is ignored.
  - READY: `rnd_valid_o=1`. `run_i=1` → one advance; `run_i=0` → state and outputs hold. `seed_valid_i` → LOAD (word count=1) and `rnd_valid_o` drops in the same registered update.
- Latency: `rnd_valid_o` rises exactly 2+WARMUP cycles after the first seed strobe edge, assuming back-to-back words.
- Clear sequencing, independent of the FSM:
  - A rising edge of `clear_req_i` loads the clear counter with CLR_CYCLES.
  - `clear_o` = (counter≠0), registered; the counter decrements each cycle.
  - A new edge while counting reloads the counter; a held-high `clear_req_i` does not retrigger.
  - `clear_o` is independent of `rnd_valid_o`; it may fire in IDLE.
- Simultaneous `seed_valid_i` and `run_i` in READY: the seed shift wins and no advance happens.
- Mid-operation reset: immediately returns to the reset values; `clear_o` drops asynchronously.

Decomposition:
- Package msk_rnd_pkg holds:
  - FSM state typedef (IDLE, LOAD, WARM, READY).
  - LFSR_W=64.
  - Tap constants 63, 62, 60, 59.
  - SEED_WORDS=2.
- One sub-module, msk_lfsr_unroll: a combinational N-step LFSR next-state function, parameterised by step count. The top instantiates it with OUT_W.

Test Plan:
- Reset then idle 10 cycles → `rnd_o=0`, `rnd_bt_o=0`, `rnd_valid_o=0`, `clear_o=0`, `busy_o=0`.
- WARMUP=0; seed 0x00000000 then 0x0000003C → next cycle `rnd_valid_o=1`, `rnd_o=2'b00`, `rnd_bt_o=4'b1111`. With `run_i=0` for 5 cycles the values hold. With `run_i=1` for one cycle → `rnd_o=00`, `rnd_bt_o=0000` (s=0xF00).
- WARMUP=0; seed two zero words → state forced to 1 → `rnd_o=2'b01`, `rnd_bt_o=0`. One run → `rnd_o=0`, `rnd_bt_o=0`.
- WARMUP=64; seed strobes at cycles 0 and 1 → `busy_o=1` during cycles 1..65, `rnd_valid_o` rises at cycle 66. Outputs match a reference LFSR model over 1000 random `run_i` cycles.
- `clear_req_i` pulses high for 5 cycles → `clear_o` high exactly 2 cycles starting the cycle after the edge. A second edge during counting extends the high period to 2 cycles after that edge.
- rst_n asserted during WARM, then re-seed → FSM restarts from IDLE, no stale `rnd_valid_o`. `seed_valid_i` in READY → `rnd_valid_o` low for the next 2+WARMUP cycles.
